gpio_bus_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single register port of the GPIO peripheral (sel/addr/we/wdata/rdata) between two bus masters, e.g. the CPU load/store unit and a debug/DMA master. Each master uses a req/ack handshake. The arbiter registers the winning request onto the GPIO port for exactly one access cycle. It then returns that cycle's read data with a one-cycle ack pulse.

---
 rtl/gpio_arb_pkg.sv | 16 +
 rtl/gpio_arb_rr2.sv | 49 ++++
 rtl/gpio_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared types and constants for the two-master GPIO port arbiter.
package gpio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } arb_state_t;

   localparam int GPIO_ARB_ADDR_W = 14;
   localparam int GPIO_ARB_DATA_W = 32;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/gpio_arb_rr2.sv
// gpio_arb_rr2: combinational two-way round-robin pick.
// With GPIO_ARB_LOCK_EN defined, a valid owner restricts the grant to that
// master; otherwise the owner inputs are ignored.
module gpio_arb_rr2
   import gpio_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       owner,
   input  logic       owner_vld,
   output logic       grant,
   output logic       grant_vld
);

`ifdef GPIO_ARB_LOCK_EN
   // Pick the winner: locked owner first, otherwise round-robin on last grant.
   always_comb begin
      grant     = M0;
      grant_vld = 1'b0;
      if (owner_vld) begin
         grant     = owner;
         grant_vld = req[owner];
      end else begin
         case (req)
            2'b01:   begin grant = M0;    grant_vld = 1'b1; end
            2'b10:   begin grant = M1;    grant_vld = 1'b1; end
            2'b11:   begin grant = ~last; grant_vld = 1'b1; end
            default: begin grant = M0;    grant_vld = 1'b0; end
         endcase
      end
   end
`else
   logic unused_owner_s;
   assign unused_owner_s = owner ^ owner_vld;

   // Pick the winner: single requester wins, ties go to the master not served last.
   always_comb begin
      grant     = M0;
      grant_vld = 1'b0;
      case (req)
         2'b01:   begin grant = M0;    grant_vld = 1'b1; end
         2'b10:   begin grant = M1;    grant_vld = 1'b1; end
         2'b11:   begin grant = ~last; grant_vld = 1'b1; end
         default: begin grant = M0;    grant_vld = 1'b0; end
      endcase
   end
`endif

endmodule

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: shares the GPIO register port between two req/ack masters.
// Each transaction: IDLE (sample/grant) -> ACCESS (one port cycle) -> ACK pulse.
// Optional macro GPIO_ARB_LOCK_EN enables master ownership via m*_lock.
module gpio_bus_arbiter
   import gpio_arb_pkg::*;
#(
   parameter int ADDR_W = GPIO_ARB_ADDR_W,
   parameter int DATA_W = GPIO_ARB_DATA_W,
   localparam int BE_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [BE_W-1:0]   m0_we,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m0_lock,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [BE_W-1:0]   m1_we,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_lock,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              sel,
   output logic [ADDR_W-1:0] addr,
   output logic [BE_W-1:0]   we,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic              busy
);

   arb_state_t        state_r;
   arb_state_t        state_nxt_s;
   logic              last_r;
   logic              gnt_r;
   logic              grant_s;
   logic              grant_vld_s;
   logic              owner_s;
   logic              owner_vld_s;
   logic [ADDR_W-1:0] req_addr_s;
   logic [BE_W-1:0]   req_we_s;
   logic [DATA_W-1:0] req_wdata_s;

   gpio_arb_rr2 u_rr2 (
      .req       ({m1_req, m0_req}),
      .last      (last_r),
      .owner     (owner_s),
      .owner_vld (owner_vld_s),
      .grant     (grant_s),
      .grant_vld (grant_vld_s)
   );

`ifdef GPIO_ARB_LOCK_EN
   logic owner_r;
   logic owner_vld_r;
   logic gnt_lock_s;

   assign gnt_lock_s  = (gnt_r == M1) ? m1_lock : m0_lock;
   assign owner_s     = owner_r;
   assign owner_vld_s = owner_vld_r;

   // Track the locking master: set when a locked transaction completes, cleared by an unlocked one.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_r     <= M0;
         owner_vld_r <= 1'b0;
      end else if (state_r == ACCESS) begin
         if (gnt_lock_s) begin
            owner_r     <= gnt_r;
            owner_vld_r <= 1'b1;
         end else if (owner_vld_r && (owner_r == gnt_r)) begin
            owner_vld_r <= 1'b0;
         end
      end
   end
`else
   logic unused_lock_s;
   assign unused_lock_s = m0_lock ^ m1_lock;
   assign owner_s       = M0;
   assign owner_vld_s   = 1'b0;
`endif

   // Select the winning master's request fields for latching onto the port.
   always_comb begin
      req_addr_s  = m0_addr;
      req_we_s    = m0_we;
      req_wdata_s = m0_wdata;
      if (grant_s == M1) begin
         req_addr_s  = m1_addr;
         req_we_s    = m1_we;
         req_wdata_s = m1_wdata;
      end else begin
         req_addr_s  = m0_addr;
         req_we_s    = m0_we;
         req_wdata_s = m0_wdata;
      end
   end

   // Next-state logic of the access sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_vld_s) begin
               state_nxt_s = ACCESS;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCESS:  state_nxt_s = ACK;
         ACK:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register and registered busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         busy    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy    <= (state_nxt_s != IDLE);
      end
   end

   // Port drive, grant bookkeeping, read-data capture and ack pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel      <= 1'b0;
         addr     <= '0;
         we       <= '0;
         wdata    <= '0;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
         last_r   <= M1;
         gnt_r    <= M0;
      end else begin
         case (state_r)
            IDLE: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               if (grant_vld_s) begin
                  sel    <= 1'b1;
                  addr   <= req_addr_s;
                  we     <= req_we_s;
                  wdata  <= req_wdata_s;
                  last_r <= grant_s;
                  gnt_r  <= grant_s;
               end
            end
            ACCESS: begin
               sel <= 1'b0;
               we  <= '0;
               if (gnt_r == M1) begin
                  m1_ack   <= 1'b1;
                  m1_rdata <= rdata;
               end else begin
                  m0_ack   <= 1'b1;
                  m0_rdata <= rdata;
               end
            end
            ACK: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
            end
            default: begin
               sel    <= 1'b0;
               we     <= '0;
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: directed self-checking bench with a small GPIO slave model.
module tb_gpio_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m1_req, m0_lock, m1_lock;
   logic [13:0] m0_addr, m1_addr;
   logic [3:0]  m0_we, m1_we;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic        sel, busy;
   logic [13:0] addr;
   logic [3:0]  we;
   logic [31:0] wdata, rdata;

   int tests_run    = 0;
   int tests_failed = 0;

   // Slave model: word memory plus a read-only pin input register at 0x010.
   logic [31:0] mem [16] = '{default: 32'd0};
   logic [15:0] pin_in = 16'h5555;

   assign rdata = (addr == 14'h010) ? {19'd0, pin_in[12:0]} : mem[addr[5:2]];

   always @(posedge clk) begin
      if (sel && (we != 4'd0) && (addr != 14'h010)) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr[5:2]][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always #5 clk = ~clk;

   gpio_bus_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
      .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .sel(sel), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata), .busy(busy)
   );

   // Transaction tables for multi-master sequences.
   logic [13:0] t_addr [2][4];
   logic [3:0]  t_we   [2][4];
   logic [31:0] t_wd   [2][4];
   logic        t_lock [2][4];
   logic [31:0] t_exp  [2][4];
   int          t_n    [2];
   int          order  [$];
   int          exp_order [$];
   logic [31:0] exp_rd0, exp_rd1;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_m(input int k, input int i);
      logic act;
      act = (i < t_n[k]);
      if (k == 0) begin
         m0_req = act; m0_addr = t_addr[0][i]; m0_we = t_we[0][i];
         m0_wdata = t_wd[0][i]; m0_lock = act & t_lock[0][i];
      end else begin
         m1_req = act; m1_addr = t_addr[1][i]; m1_we = t_we[1][i];
         m1_wdata = t_wd[1][i]; m1_lock = act & t_lock[1][i];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_rd0 = 32'd0;
      exp_rd1 = 32'd0;
   endtask

   // Fixed-latency single transfer: checks port cycle, ack timing and data.
   task automatic single_xfer(input int k, input logic [13:0] a, input logic [3:0] w,
                              input logic [31:0] d, input logic [31:0] exp);
      if (k == 0) begin
         m0_req = 1'b1; m0_addr = a; m0_we = w; m0_wdata = d;
      end else begin
         m1_req = 1'b1; m1_addr = a; m1_we = w; m1_wdata = d;
      end
      @(negedge clk);
      check_val("access_sel", sel, 1'b1);
      check_val("access_addr", addr, a);
      check_val("access_we", we, w);
      if (w != 4'd0) check_val("access_wdata", wdata, d);
      check_val("access_busy", busy, 1'b1);
      check_val("access_noack", {m1_ack, m0_ack}, 2'b00);
      @(negedge clk);
      check_val("ack_sel", sel, 1'b0);
      check_val("ack_we", we, 4'd0);
      if (k == 0) begin
         check_val("ack_m0", {m1_ack, m0_ack}, 2'b01);
         check_val("ack_m0_rdata", m0_rdata, exp);
         m0_req = 1'b0;
      end else begin
         check_val("ack_m1", {m1_ack, m0_ack}, 2'b10);
         check_val("ack_m1_rdata", m1_rdata, exp);
         m1_req = 1'b0;
      end
      @(negedge clk);
      check_val("post_ack", {m1_ack, m0_ack}, 2'b00);
      check_val("post_busy", busy, 1'b0);
   endtask

   // Run both masters from the tables, record grant order via acks.
   task automatic run_seq(input int max_cyc);
      int idx0 = 0;
      int idx1 = 0;
      int cyc  = 0;
      order.delete();
      drive_m(0, 0);
      drive_m(1, 0);
      while ((idx0 < t_n[0] || idx1 < t_n[1]) && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (m0_ack && idx0 < 4) begin
            check_val("seq_m0_rdata", m0_rdata, t_exp[0][idx0]);
            check_val("seq_m1_rdata_hold", m1_rdata, exp_rd1);
            exp_rd0 = t_exp[0][idx0];
            order.push_back(0);
            idx0++;
            drive_m(0, idx0);
         end
         if (m1_ack && idx1 < 4) begin
            check_val("seq_m1_rdata", m1_rdata, t_exp[1][idx1]);
            check_val("seq_m0_rdata_hold", m0_rdata, exp_rd0);
            exp_rd1 = t_exp[1][idx1];
            order.push_back(1);
            idx1++;
            drive_m(1, idx1);
         end
      end
      check_val("seq_done_m0", idx0, t_n[0]);
      check_val("seq_done_m1", idx1, t_n[1]);
      check_val("order_len", order.size(), exp_order.size());
      for (int i = 0; i < exp_order.size(); i++) begin
         if (i < order.size()) check_val("order", order[i], exp_order[i]);
      end
      @(negedge clk);
   endtask

   task automatic fill_rd(input int k, input int i, input logic [13:0] a,
                          input logic [31:0] e, input logic lk);
      t_addr[k][i] = a; t_we[k][i] = 4'd0; t_wd[k][i] = 32'd0;
      t_lock[k][i] = lk; t_exp[k][i] = e;
   endtask

   initial begin
      m0_req = 1'b0; m0_addr = '0; m0_we = '0; m0_wdata = '0; m0_lock = 1'b0;
      m1_req = 1'b0; m1_addr = '0; m1_we = '0; m1_wdata = '0; m1_lock = 1'b0;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 4; i++) fill_rd(k, i, 14'h000, 32'd0, 1'b0);

      // Reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_sel", sel, 1'b0);
      check_val("rst_we", we, 4'd0);
      check_val("rst_acks", {m1_ack, m0_ack}, 2'b00);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
      rst = 1'b0;
      exp_rd0 = 32'd0; exp_rd1 = 32'd0;
      @(negedge clk);

      // Single write, readback, pin read
      single_xfer(0, 14'h020, 4'b0001, 32'hAAAAAAAA, 32'h00000000);
      single_xfer(0, 14'h020, 4'b0000, 32'h0, 32'h000000AA);
      check_val("m1_rdata_untouched", m1_rdata, 32'd0);
      single_xfer(1, 14'h010, 4'b0000, 32'h0, 32'h00001555);
      check_val("m0_rdata_untouched", m0_rdata, 32'h000000AA);

      // Contention out of reset: alternate 0,1,0,1
      do_reset();
      t_n[0] = 2; t_n[1] = 2;
      fill_rd(0, 0, 14'h020, 32'h000000AA, 1'b0);
      fill_rd(0, 1, 14'h020, 32'h000000AA, 1'b0);
      fill_rd(1, 0, 14'h010, 32'h00001555, 1'b0);
      fill_rd(1, 1, 14'h010, 32'h00001555, 1'b0);
      exp_order = '{0, 1, 0, 1};
      run_seq(40);

      // Reset during ACCESS: no ack, then normal operation
      m0_req = 1'b1; m0_addr = 14'h028; m0_we = 4'hF; m0_wdata = 32'h12345678; m0_lock = 1'b0;
      @(negedge clk);
      check_val("mid_access_sel", sel, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m0_req = 1'b0;
      check_val("mid_rst_sel", sel, 1'b0);
      check_val("mid_rst_we", we, 4'd0);
      check_val("mid_rst_acks", {m1_ack, m0_ack}, 2'b00);
      check_val("mid_rst_busy", busy, 1'b0);
      @(negedge clk);
      check_val("mid_rst_noack", {m1_ack, m0_ack}, 2'b00);
      single_xfer(1, 14'h028, 4'b0000, 32'h0, 32'h12345678);

      // Lock: m0 locked read then unlocked write, m1 waiting
      do_reset();
      t_n[0] = 2; t_n[1] = 1;
      fill_rd(0, 0, 14'h020, 32'h000000AA, 1'b1);
      t_addr[0][1] = 14'h020; t_we[0][1] = 4'b0001; t_wd[0][1] = 32'h00000055;
      t_lock[0][1] = 1'b0; t_exp[0][1] = 32'h000000AA;
      fill_rd(1, 0, 14'h010, 32'h00001555, 1'b0);
`ifdef GPIO_ARB_LOCK_EN
      exp_order = '{0, 0, 1};
`else
      exp_order = '{0, 1, 0};
`endif
      run_seq(40);
      single_xfer(1, 14'h020, 4'b0000, 32'h0, 32'h00000055);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
